alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter and sequencer for the shared combinational `alu`. It accepts operation requests through valid/ready handshakes and registers the winning operands onto the ALU inputs. One cycle later it captures the ALU outputs and holds them on a single response channel tagged with the requester ID. It sits between the two datapath clients and the single `alu` instance, which is instantiated beside it.

## Interface
- WIDTH, 4, operand and result width; passed unchanged to `alu`
- CNT_W, 8, width of the completed-operation counter
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- req0_valid / req1_valid  in  1  requester N presents an operation
- req0_ready / req1_ready  out  1  requester N's operation is accepted this cycle
- req0_op / req1_op  in  3  ALU op code, passed through unchanged
- req0_c / req1_c  in  1  carry-in
- req0_x, req0_y / req1_x, req1_y  in  WIDTH  operands
- alu_op  out  3  registered op code to `alu`
- alu_in_c  out  1  registered carry-in to `alu`
- alu_in_x, alu_in_y  out  WIDTH  registered operands to `alu`
- alu_out_s  in  WIDTH  result from `alu`
- alu_out_c, alu_zero, alu_overflow  in  1 each  flags from `alu`
- rsp_valid  out  1  a result is held for the consumer
- rsp_ready  in  1  the consumer takes the result
- rsp_id  out  1  requester that issued the held result
- rsp_s  out  WIDTH  captured result
- rsp_c, rsp_zero, rsp_ovf  out  1 each  captured flags
- busy  out  1  high in EXEC or RESP
- ops_done  out  CNT_W  count of completed responses

## Operation
- FSM states:
  - IDLE: if any `reqN_valid` is high, assert `reqN_ready` for the arbitration winner, combinationally, in the same cycle. On `valid&ready`, load op/c/x/y into the `alu_*` registers, latch the id, go to EXEC. With no valid, stay in IDLE.
  - EXEC: exactly 1 cycle. On its closing edge, capture `alu_out_s/alu_out_c/alu_zero/alu_overflow` into `rsp_s/rsp_c/rsp_zero/rsp_ovf`, then go to RESP.
  - RESP: `rsp_valid`=1. On `rsp_valid&rsp_ready`, increment `ops_done` and go to IDLE. Otherwise hold all `rsp_*` stable.
- Ready is asserted only in IDLE. Requests made in EXEC or RESP wait.
- Arbitration is recomputed every IDLE cycle. There is no lock: a requester that drops valid before acceptance loses nothing and gains nothing.
- Round-robin pointer `last`: when both requesters are valid, grant the one not equal to `last`. Update `last` only on acceptance.
- Op codes 0–7 are forwarded unchecked. Arithmetic semantics belong to `alu`; this block never modifies operands or flags.
- The `alu_*` registers keep their last values outside EXEC. They are not cleared after use.
- `ops_done` wraps from 2^CNT_W−1 to 0.
- `rsp_ready` while `rsp_valid`=0 is ignored.

## Timing
- Reset values: state IDLE, `last`=1 (so req0 wins the first contention), all `alu_*`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_s`=0, all `rsp_*` flags 0, `busy`=0, `ops_done`=0. Both `reqN_ready` outputs are 0 during reset.
- Request accepted at edge E0 → EXEC for the cycle after E0 → `rsp_valid` rises after edge E1. Latency is 2 cycles.
- With `rsp_ready` tied high, throughput is 1 operation per 3 cycles: accept, EXEC, RESP.
- Reset asserted in EXEC or RESP aborts the transaction. After that edge, `rsp_valid`=0 and no response is ever produced for the aborted request. `ops_done` is reset.
- The requester must hold op/c/x/y stable while valid and not ready. The arbiter samples them only at the accept edge.

## Configuration
- Macro `ALU_ARB_RR_EN`.
- Defined: round-robin arbitration as described above.
- Undefined: fixed priority; req0 always wins when both are valid. The `last` register still exists but does not affect arbitration. All other behaviour is identical.

## Test plan
- Reset, then req0 op=3'b000 x=4'h1 y=4'h1 c=0 → `req0_ready` in the same cycle; `rsp_valid` 2 cycles later with id=0, s=4'h2, c=0, zero=0, ovf=0; `ops_done`=1 after `rsp_ready`.
- Both requesters valid continuously, op=0, req0 x=4'h7 y=4'h1, req1 x=4'hF y=4'h1 → with RR_EN, grants alternate 0,1,0,1. Responses: id0 s=4'h8 ovf=1; id1 s=4'h0 c=1 zero=1. Without RR_EN, only req0 is granted.
- Hold `rsp_ready`=0 for 5 cycles while req1 is valid → `rsp_*` stable and `req1_ready`=0 throughout. req1 is accepted in the first IDLE cycle after the handshake.
- Assert `rst` in the EXEC cycle → next cycle `rsp_valid`=0, `busy`=0, `ops_done`=0, and no response appears later.
- Complete 256 operations with CNT_W=8 → `ops_done` wraps to 0.
- Pulse `req0_valid` for one cycle while in RESP → never accepted, and no response with id=0 is generated.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response and ALU-side bus of the two-requester ALU arbiter
// slave  : arbiter view (takes requests and ALU results, drives ready, ALU inputs and response)
// master : client/consumer/ALU view (the opposite directions)
interface alu_arbiter_if #(parameter int WIDTH = 4);
  logic             req0_valid, req0_ready, req0_c;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_x, req0_y;
  logic             req1_valid, req1_ready, req1_c;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_x, req1_y;
  logic [2:0]       alu_op;
  logic             alu_in_c;
  logic [WIDTH-1:0] alu_in_x, alu_in_y, alu_out_s;
  logic             alu_out_c, alu_zero, alu_overflow;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_c, rsp_zero, rsp_ovf;
  logic [WIDTH-1:0] rsp_s;
  modport slave (
    input  req0_valid, req0_op, req0_c, req0_x, req0_y,
    input  req1_valid, req1_op, req1_c, req1_x, req1_y,
    input  alu_out_s, alu_out_c, alu_zero, alu_overflow, rsp_ready,
    output req0_ready, req1_ready, alu_op, alu_in_c, alu_in_x, alu_in_y,
    output rsp_valid, rsp_id, rsp_s, rsp_c, rsp_zero, rsp_ovf
  );
  modport master (
    output req0_valid, req0_op, req0_c, req0_x, req0_y,
    output req1_valid, req1_op, req1_c, req1_x, req1_y,
    output alu_out_s, alu_out_c, alu_zero, alu_overflow, rsp_ready,
    input  req0_ready, req1_ready, alu_op, alu_in_c, alu_in_x, alu_in_y,
    input  rsp_valid, rsp_id, rsp_s, rsp_c, rsp_zero, rsp_ovf
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter/sequencer for a shared combinational ALU
// Ports: clk, rst (sync, active-high); bus (alu_arbiter_if.slave: requests, ALU in/out, response);
//        busy (high in EXEC/RESP); ops_done (completed-response counter, wraps).
// Macro ALU_ARB_RR_EN: defined = round-robin on contention, undefined = req0 fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           r_state, w_next;
  logic             r_last, r_id, w_pick1, w_acc, w_done;
  logic [2:0]       r_op;
  logic             r_c, r_oc, r_z, r_v;
  logic [WIDTH-1:0] r_x, r_y, r_s;
  logic [CNT_W-1:0] r_cnt;
`ifdef ALU_ARB_RR_EN
  assign w_pick1 = bus.req1_valid & (~bus.req0_valid | ~r_last);
`else
  logic w_unused_last;
  assign w_unused_last = r_last;
  assign w_pick1 = bus.req1_valid & ~bus.req0_valid;
`endif
  // ready is gated by rst so both grants stay low while reset is held
  assign w_acc  = (r_state == IDLE) & ~rst & (bus.req0_valid | bus.req1_valid);
  assign w_done = (r_state == RESP) & bus.rsp_ready;
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (w_acc ? EXEC : IDLE) :
             r_state == EXEC ? RESP : (bus.rsp_ready ? IDLE : RESP);
  always_comb begin
    bus.req0_ready = w_acc & ~w_pick1;
    bus.req1_ready = w_acc & w_pick1;
    bus.rsp_valid  = r_state == RESP;
    busy           = r_state != IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_op   <= '0;
      r_c    <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
      r_id   <= 1'b0;
      r_last <= 1'b1;
      r_s    <= '0;
      r_oc   <= 1'b0;
      r_z    <= 1'b0;
      r_v    <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_acc) begin
        r_op   <= w_pick1 ? bus.req1_op : bus.req0_op;
        r_c    <= w_pick1 ? bus.req1_c : bus.req0_c;
        r_x    <= w_pick1 ? bus.req1_x : bus.req0_x;
        r_y    <= w_pick1 ? bus.req1_y : bus.req0_y;
        r_id   <= w_pick1;
        r_last <= w_pick1;
      end
      if (r_state == EXEC) begin
        r_s  <= bus.alu_out_s;
        r_oc <= bus.alu_out_c;
        r_z  <= bus.alu_zero;
        r_v  <= bus.alu_overflow;
      end
      if (w_done) r_cnt <= r_cnt + 1'b1;
    end
  // r_id only changes on acceptance in IDLE, so it stays stable for the whole RESP phase
  assign bus.alu_op   = r_op;
  assign bus.alu_in_c = r_c;
  assign bus.alu_in_x = r_x;
  assign bus.alu_in_y = r_y;
  assign bus.rsp_id   = r_id;
  assign bus.rsp_s    = r_s;
  assign bus.rsp_c    = r_oc;
  assign bus.rsp_zero = r_z;
  assign bus.rsp_ovf  = r_v;
  assign ops_done     = r_cnt;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed self-checking bench for alu_arbiter with a stand-in ALU
module tb_alu_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [7:0] ops_done;
  int         errors = 0, checks = 0;
  bit         m_busy, m_last, m_id;
  int         m_age, exp_done;
  logic [6:0] m_exp;
  alu_arbiter_if #(.WIDTH(4)) bus();
  alu_arbiter #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy), .ops_done(ops_done));
  always #5 clk = ~clk;
  function automatic logic [6:0] alu_f(logic [2:0] op, logic c, logic [3:0] x, logic [3:0] y);
    logic [4:0] r;
    logic v;
    r = '0;
    v = 1'b0;
    case (op)
      3'd0: begin r = {1'b0, x} + {1'b0, y} + {4'b0, c}; v = (x[3] == y[3]) && (r[3] != x[3]); end
      3'd1: begin r = {1'b0, x} - {1'b0, y} - {4'b0, c}; v = (x[3] != y[3]) && (r[3] != x[3]); end
      3'd2: r = {1'b0, x & y};
      3'd3: r = {1'b0, x | y};
      3'd4: r = {1'b0, x ^ y};
      3'd5: r = {c, ~x};
      3'd6: r = {x, c};
      default: r = {x[0], c, x[3:1]};
    endcase
    return {r[4], r[3:0], r[3:0] == 4'd0, v};
  endfunction
  always_comb {bus.alu_out_c, bus.alu_out_s, bus.alu_zero, bus.alu_overflow} = alu_f(bus.alu_op, bus.alu_in_c, bus.alu_in_x, bus.alu_in_y);
  function automatic int win();
    if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_RR_EN
      return m_last ? 0 : 1;
`else
      return 0;
`endif
    end
    return bus.req1_valid ? 1 : 0;
  endfunction
  function automatic logic [6:0] req_res(int w);
    return w == 1 ? alu_f(bus.req1_op, bus.req1_c, bus.req1_x, bus.req1_y) : alu_f(bus.req0_op, bus.req0_c, bus.req0_x, bus.req0_y);
  endfunction
  task automatic advance();
    if (rst) begin
      m_busy = 0; m_last = 1; exp_done = 0;
    end else if (!m_busy) begin
      if (bus.req0_valid || bus.req1_valid) begin
        m_id = (win() == 1); m_exp = req_res(win()); m_last = m_id; m_busy = 1; m_age = 1;
      end
    end else if (m_age >= 2 && bus.rsp_ready) begin
      m_busy = 0; exp_done = (exp_done + 1) % 256;
    end else m_age++;
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(int n, logic v, logic [2:0] op, logic c, logic [3:0] x, logic [3:0] y);
    if (n == 0) begin bus.req0_valid = v; bus.req0_op = op; bus.req0_c = c; bus.req0_x = x; bus.req0_y = y; end
    else begin bus.req1_valid = v; bus.req1_op = op; bus.req1_c = c; bus.req1_x = x; bus.req1_y = y; end
  endtask
  task automatic do_reset();
    rst = 1; bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 0;
    advance(); advance();
    rst = 0;
  endtask
  task automatic drain();
    bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 1;
    repeat (4) advance();
  endtask
  task automatic test_reset();
    rst = 1;
    set_req(0, 1, 3'd0, 0, 4'h1, 4'h1); set_req(1, 1, 3'd0, 0, 4'h1, 4'h1);
    advance();
    @(negedge clk);
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got=%b want=0", bus.req0_ready); end
    checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 got=%b want=0", bus.req1_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (ops_done !== 8'd0) begin errors++; $display("FAIL reset_ops_done got=%0d want=0", ops_done); end
    checks++; if ({bus.alu_op, bus.alu_in_c, bus.alu_in_x, bus.alu_in_y} !== 12'd0) begin errors++; $display("FAIL reset_alu_regs got=%h want=0", {bus.alu_op, bus.alu_in_c, bus.alu_in_x, bus.alu_in_y}); end
    checks++; if ({bus.rsp_id, bus.rsp_s, bus.rsp_c, bus.rsp_zero, bus.rsp_ovf} !== 8'd0) begin errors++; $display("FAIL reset_rsp got=%h want=0", {bus.rsp_id, bus.rsp_s, bus.rsp_c, bus.rsp_zero, bus.rsp_ovf}); end
    bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 0;
    advance();
    rst = 0;
  endtask
  task automatic test_basic();
    do_reset();
    bus.rsp_ready = 1;
    set_req(0, 1, 3'd0, 0, 4'h1, 4'h1);
    @(negedge clk);
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b want=1", bus.req0_ready); end
    advance();
    bus.req0_valid = 0;
    @(negedge clk);
    checks++; if ({busy, bus.rsp_valid} !== 2'b10) begin errors++; $display("FAIL basic_exec busy/valid got=%b want=10", {busy, bus.rsp_valid}); end
    advance();
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_latency rsp_valid got=%b want=1", bus.rsp_valid); end
    checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL basic_id got=%b want=0", bus.rsp_id); end
    checks++; if ({bus.rsp_c, bus.rsp_s, bus.rsp_zero, bus.rsp_ovf} !== 7'b0_0010_0_0) begin errors++; $display("FAIL basic_payload got=%b want=0001000", {bus.rsp_c, bus.rsp_s, bus.rsp_zero, bus.rsp_ovf}); end
    advance();
    @(negedge clk);
    checks++; if (ops_done !== 8'd1) begin errors++; $display("FAIL basic_ops_done got=%0d want=1", ops_done); end
    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_rsp_drop got=%b want=0", bus.rsp_valid); end
  endtask
  task automatic test_contention();
    int g = 0;
    logic e_id;
    do_reset();
    bus.rsp_ready = 1;
    set_req(0, 1, 3'd0, 0, 4'h7, 4'h1); set_req(1, 1, 3'd0, 0, 4'hF, 4'h1);
    for (int cyc = 0; cyc < 40 && g < 4; cyc++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
`ifdef ALU_ARB_RR_EN
        e_id = g[0];
`else
        e_id = 1'b0;
`endif
        checks++; if (bus.rsp_id !== e_id) begin errors++; $display("FAIL contention_id%0d got=%b want=%b", g, bus.rsp_id, e_id); end
        checks++; if ({bus.rsp_c, bus.rsp_s, bus.rsp_zero, bus.rsp_ovf} !== (bus.rsp_id ? 7'b1_0000_1_0 : 7'b0_1000_0_1)) begin errors++; $display("FAIL contention_payload%0d got=%b id=%b", g, {bus.rsp_c, bus.rsp_s, bus.rsp_zero, bus.rsp_ovf}, bus.rsp_id); end
        g++;
      end
      advance();
    end
    checks++; if (g != 4) begin errors++; $display("FAIL contention_timeout got=%0d responses want=4", g); end
  endtask
  task automatic test_backpressure();
    logic [7:0] snap;
    do_reset();
    set_req(0, 1, 3'd1, 1, 4'h5, 4'h3);
    @(negedge clk);
    advance();
    set_req(0, 0, 3'd0, 0, 4'h0, 4'h0); set_req(1, 1, 3'd4, 0, 4'hA, 4'h3);
    @(negedge clk);
    advance();
    @(negedge clk);
    snap = {bus.rsp_id, bus.rsp_c, bus.rsp_s, bus.rsp_zero, bus.rsp_ovf};
    checks++; if ({bus.rsp_valid, snap} !== {1'b1, 1'b0, 7'b0_0001_0_0}) begin errors++; $display("FAIL bp_first got=%h want=%h", {bus.rsp_valid, snap}, {1'b1, 8'h04}); end
    for (int i = 0; i < 5; i++) begin
      advance();
      @(negedge clk);
      checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_c, bus.rsp_s, bus.rsp_zero, bus.rsp_ovf} !== {1'b1, snap}) begin errors++; $display("FAIL bp_stable%0d got=%h want=%h", i, {bus.rsp_valid, bus.rsp_id, bus.rsp_c, bus.rsp_s, bus.rsp_zero, bus.rsp_ovf}, {1'b1, snap}); end
      checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL bp_req1_ready%0d got=%b want=0", i, bus.req1_ready); end
    end
    bus.rsp_ready = 1;
    advance();
    @(negedge clk);
    checks++; if ({bus.req1_ready, bus.rsp_valid} !== 2'b10) begin errors++; $display("FAIL bp_req1_accept ready/valid got=%b want=10", {bus.req1_ready, bus.rsp_valid}); end
    advance();
    bus.req1_valid = 0;
    @(negedge clk);
    advance();
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_c, bus.rsp_s, bus.rsp_zero, bus.rsp_ovf} !== 9'b1_1_0_1001_0_0) begin errors++; $display("FAIL bp_second got=%b want=110100100", {bus.rsp_valid, bus.rsp_id, bus.rsp_c, bus.rsp_s, bus.rsp_zero, bus.rsp_ovf}); end
  endtask
  task automatic test_reset_exec();
    bus.rsp_ready = 1;
    set_req(0, 1, 3'd0, 0, 4'h3, 4'h4);
    @(negedge clk);
    advance();
    bus.req0_valid = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rexec_busy got=%b want=1", busy); end
    rst = 1;
    advance();
    rst = 0;
    @(negedge clk);
    checks++; if ({bus.rsp_valid, busy, ops_done} !== 10'd0) begin errors++; $display("FAIL rexec_after valid/busy/ops got=%h want=0", {bus.rsp_valid, busy, ops_done}); end
    for (int i = 0; i < 6; i++) begin
      advance();
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rexec_ghost%0d got=%b want=0", i, bus.rsp_valid); end
    end
  endtask
  task automatic test_resp_pulse();
    int n = 0;
    do_reset();
    set_req(1, 1, 3'd2, 0, 4'hC, 4'hA);
    @(negedge clk);
    advance();
    bus.req1_valid = 0;
    @(negedge clk);
    advance();
    @(negedge clk);
    set_req(0, 1, 3'd0, 0, 4'h1, 4'h1);
    #1;
    checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL pulse_ready got=%b want=0", bus.req0_ready); end
    advance();
    bus.req0_valid = 0; bus.rsp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        n++;
        checks++; if ({bus.rsp_id, bus.rsp_s} !== 5'b1_1000) begin errors++; $display("FAIL pulse_rsp got=%b want=11000", {bus.rsp_id, bus.rsp_s}); end
      end
      advance();
    end
    checks++; if (n != 1) begin errors++; $display("FAIL pulse_count got=%0d want=1", n); end
  endtask
  task automatic test_random();
    bit acc0 = 0, acc1 = 0, e_r0, e_r1, e_rv;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (bus.req0_valid && !acc0) bus.req0_valid = ($urandom_range(0, 3) != 0);
      else set_req(0, 1'($urandom_range(0, 1)), 3'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
      if (bus.req1_valid && !acc1) bus.req1_valid = ($urandom_range(0, 3) != 0);
      else set_req(1, 1'($urandom_range(0, 1)), 3'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
      bus.rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      e_r0 = !m_busy && bus.req0_valid && win() == 0;
      e_r1 = !m_busy && bus.req1_valid && win() == 1;
      e_rv = m_busy && m_age >= 2;
      checks++; if ({bus.req0_ready, bus.req1_ready} !== {e_r0, e_r1}) begin errors++; $display("FAIL rand_ready cyc%0d got=%b want=%b", i, {bus.req0_ready, bus.req1_ready}, {e_r0, e_r1}); end
      checks++; if ({bus.rsp_valid, busy} !== {e_rv, m_busy}) begin errors++; $display("FAIL rand_valid_busy cyc%0d got=%b want=%b", i, {bus.rsp_valid, busy}, {e_rv, m_busy}); end
      checks++; if (ops_done !== 8'(exp_done)) begin errors++; $display("FAIL rand_ops_done cyc%0d got=%0d want=%0d", i, ops_done, exp_done); end
      if (e_rv) begin
        checks++; if ({bus.rsp_id, bus.rsp_c, bus.rsp_s, bus.rsp_zero, bus.rsp_ovf} !== {m_id, m_exp}) begin errors++; $display("FAIL rand_rsp cyc%0d got=%h want=%h", i, {bus.rsp_id, bus.rsp_c, bus.rsp_s, bus.rsp_zero, bus.rsp_ovf}, {m_id, m_exp}); end
      end
      acc0 = bus.req0_valid && e_r0;
      acc1 = bus.req1_valid && e_r1;
      advance();
    end
  endtask
  task automatic test_wrap();
    do_reset();
    bus.rsp_ready = 1;
    set_req(0, 1, 3'd3, 0, 4'h5, 4'h2);
    for (int i = 0; i < 1000 && exp_done != 255; i++) advance();
    checks++; if (exp_done != 255) begin errors++; $display("FAIL wrap_timeout got=%0d want=255", exp_done); end
    checks++; if (ops_done !== 8'd255) begin errors++; $display("FAIL wrap_255 got=%0d want=255", ops_done); end
    for (int i = 0; i < 10 && exp_done != 0; i++) advance();
    checks++; if (ops_done !== 8'd0) begin errors++; $display("FAIL wrap_zero got=%0d want=0", ops_done); end
  endtask
  initial begin
    set_req(0, 0, 3'd0, 0, 4'h0, 4'h0); set_req(1, 0, 3'd0, 0, 4'h0, 4'h0);
    bus.rsp_ready = 0;
    test_reset();
    test_basic();
    test_contention();
    drain();
    test_backpressure();
    drain();
    test_reset_exec();
    test_resp_pulse();
    drain();
    test_random();
    drain();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end
endmodule
